mem_access_stage: RTL and testbench

//   MEM stage of the 5-stage MIPS pipeline. It consumes the EX/MEM buffer outputs and

---
 rtl/mem_access_stage_pkg.sv | 22 ++
 rtl/mem_access_stage_if.sv | 39 +++
 rtl/mem_access_stage_buffer_memwb.sv | 25 ++
 rtl/mem_access_stage.sv | 105 ++++++++++
 tb/tb_mem_access_stage.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM pipeline stage: word type, FSM state encoding and the
// MEM/WB register payload.
package mem_access_stage_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    MEMST_IDLE = 1'b0,
    MEMST_BUSY = 1'b1
  } memst_e;

  typedef struct packed {
    word_t      read_data;
    word_t      alu_result;
    logic [4:0] wb_address;
    logic       reg_write;
    logic       memto_reg;
  } memwb_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM -> MEM stage inputs, branch feedback to IF, stall and MEM/WB outputs.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  word_t      Branch_Target;
  word_t      Result;
  word_t      MemWriteData;
  logic [4:0] RegDstAddress;
  logic       zero;
  logic       Branch;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite_in;
  logic       MemtoReg_in;

  logic       PCSrc;
  word_t      PC_Branch;
  logic       stall;
  word_t      ReadData;
  word_t      ALUResult;
  logic [4:0] WBAddress;
  logic       RegWrite_out;
  logic       MemtoReg_out;

  modport master (
    output Branch_Target, Result, MemWriteData, RegDstAddress, zero, Branch,
           MemRead, MemWrite, RegWrite_in, MemtoReg_in,
    input  PCSrc, PC_Branch, stall, ReadData, ALUResult, WBAddress,
           RegWrite_out, MemtoReg_out
  );

  modport slave (
    input  Branch_Target, Result, MemWriteData, RegDstAddress, zero, Branch,
           MemRead, MemWrite, RegWrite_in, MemtoReg_in,
    output PCSrc, PC_Branch, stall, ReadData, ALUResult, WBAddress,
           RegWrite_out, MemtoReg_out
  );

endinterface

// File: rtl/mem_access_stage_buffer_memwb.sv
// MEM/WB pipeline register. A bubble clears the control bits and holds the data fields.
module buffer_memwb
  import mem_access_stage_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   bubble,
  input  memwb_t d,
  output memwb_t q
);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (bubble) begin
      q.reg_write <= 1'b0;
      q.memto_reg <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: word-addressed data memory with parameterised access latency, branch
// resolution back to fetch, and the MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int MEM_LATENCY = 0
) (
  input logic               clk,
  input logic               reset,
  mem_access_stage_if.slave bus
);

  localparam int         DEPTH    = 2 ** ADDR_BITS;
  localparam bit         HAS_LAT  = (MEM_LATENCY > 0);
  localparam logic [3:0] CNT_INIT = HAS_LAT ? 4'(MEM_LATENCY - 1) : 4'd0;

  memst_e                 state;
  logic [3:0]             cnt;
  word_t                  mem [DEPTH];
  logic [ADDR_BITS-1:0]   idx;
  logic                   req;
  logic                   stall;
  logic                   complete;
  memwb_t                 memwb_d;
  memwb_t                 memwb_q;

  // Byte offset and bits above the depth are dropped, so addresses alias.
  assign idx = bus.Result[ADDR_BITS+1:2];
  assign req = bus.MemRead | bus.MemWrite;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    stall    = 1'b0;
    complete = 1'b0;
    if (reset) begin
      unique case (state)
        MEMST_IDLE: begin
          if (req && HAS_LAT) stall    = 1'b1;
          else                complete = 1'b1;
        end
        MEMST_BUSY: begin
          if (cnt != 4'd0) stall    = 1'b1;
          else             complete = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MEMST_IDLE;
      cnt   <= 4'd0;
    end else begin
      unique case (state)
        MEMST_IDLE: begin
          if (req && HAS_LAT) begin
            state <= MEMST_BUSY;
            cnt   <= CNT_INIT;
          end
        end
        MEMST_BUSY: begin
          if (cnt != 4'd0) cnt   <= cnt - 4'd1;
          else             state <= MEMST_IDLE;
        end
        default: state <= MEMST_IDLE;
      endcase
    end
  end

  // NOTE: the memory array has no reset; clearing it would force a flop-based array
  // and serves no functional purpose. Only the write enable depends on reset.
  always_ff @(posedge clk) begin
    if (complete && bus.MemWrite) mem[idx] <= bus.MemWriteData;
  end

  // A simultaneous load sees the pre-write word because the write lands at the edge.
  always_comb begin
    memwb_d            = '0;
    memwb_d.read_data  = mem[idx];
    memwb_d.alu_result = bus.Result;
    memwb_d.wb_address = bus.RegDstAddress;
    memwb_d.reg_write  = bus.RegWrite_in;
    memwb_d.memto_reg  = bus.MemtoReg_in;
  end

  buffer_memwb u_memwb (
    .clk    (clk),
    .reset  (reset),
    .bubble (stall),
    .d      (memwb_d),
    .q      (memwb_q)
  );

  assign bus.PCSrc        = bus.Branch & bus.zero;
  assign bus.PC_Branch    = bus.Branch_Target;
  assign bus.stall        = stall;
  assign bus.ReadData     = memwb_q.read_data;
  assign bus.ALUResult    = memwb_q.alu_result;
  assign bus.WBAddress    = memwb_q.wb_address;
  assign bus.RegWrite_out = memwb_q.reg_write;
  assign bus.MemtoReg_out = memwb_q.memto_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: three instances (latency 0, 2, 3) share one
// stimulus driver selected by sel; a monitor pops expectations on each completion.
`timescale 1ns/1ps
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  typedef struct {
    word_t      rd;
    word_t      alu;
    logic [4:0] wba;
    logic       rw;
    logic       m2r;
    logic       chk;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic [2:0] rst = 3'b000;
  int         sel = 0;
  int         n_vec = 0;
  int         n_fail = 0;
  exp_t       exp_q[$];

  word_t      branch_target, result, wdata;
  logic [4:0] dst;
  logic       zero, branch, mrd, mwr, rw_in, m2r_in;
  logic       valid = 1'b0;
  logic       fire = 1'b0;

  logic       stall_a [3];
  logic       pcsrc_a [3];
  word_t      pcb_a [3];
  word_t      rd_a [3];
  word_t      alu_a [3];
  logic [4:0] wba_a [3];
  logic       rw_a [3];
  logic       m2r_a [3];

  logic       stall_m, pcsrc_m, rw_m, m2r_m;
  word_t      pcb_m, rd_m, alu_m;
  logic [4:0] wba_m;

  always #5 clk = ~clk;

  mem_access_stage_if b0 ();
  mem_access_stage_if b1 ();
  mem_access_stage_if b2 ();

  mem_access_stage #(.ADDR_BITS(8), .MEM_LATENCY(0)) u_lat0 (.clk(clk), .reset(rst[0]), .bus(b0));
  mem_access_stage #(.ADDR_BITS(8), .MEM_LATENCY(2)) u_lat2 (.clk(clk), .reset(rst[1]), .bus(b1));
  mem_access_stage #(.ADDR_BITS(8), .MEM_LATENCY(3)) u_lat3 (.clk(clk), .reset(rst[2]), .bus(b2));

`define HOOK(b, k) \
  assign b.Branch_Target = (sel == k) ? branch_target : '0; \
  assign b.Result        = (sel == k) ? result : '0; \
  assign b.MemWriteData  = (sel == k) ? wdata : '0; \
  assign b.RegDstAddress = (sel == k) ? dst : '0; \
  assign b.zero          = (sel == k) ? zero : 1'b0; \
  assign b.Branch        = (sel == k) ? branch : 1'b0; \
  assign b.MemRead       = (sel == k) ? mrd : 1'b0; \
  assign b.MemWrite      = (sel == k) ? mwr : 1'b0; \
  assign b.RegWrite_in   = (sel == k) ? rw_in : 1'b0; \
  assign b.MemtoReg_in   = (sel == k) ? m2r_in : 1'b0; \
  assign stall_a[k] = b.stall; \
  assign pcsrc_a[k] = b.PCSrc; \
  assign pcb_a[k]   = b.PC_Branch; \
  assign rd_a[k]    = b.ReadData; \
  assign alu_a[k]   = b.ALUResult; \
  assign wba_a[k]   = b.WBAddress; \
  assign rw_a[k]    = b.RegWrite_out; \
  assign m2r_a[k]   = b.MemtoReg_out;

  `HOOK(b0, 0)
  `HOOK(b1, 1)
  `HOOK(b2, 2)

  assign stall_m = stall_a[sel];
  assign pcsrc_m = pcsrc_a[sel];
  assign pcb_m   = pcb_a[sel];
  assign rd_m    = rd_a[sel];
  assign alu_m   = alu_a[sel];
  assign wba_m   = wba_a[sel];
  assign rw_m    = rw_a[sel];
  assign m2r_m   = m2r_a[sel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: an issued instruction completes on a rising edge with stall low.
  always @(posedge clk) fire <= valid && !stall_m;

  always @(negedge clk) begin
    if (fire) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk) check({e.tag, ".ReadData"}, rd_m, e.rd);
        check({e.tag, ".ALUResult"},    alu_m, e.alu);
        check({e.tag, ".WBAddress"},    32'(wba_m), 32'(e.wba));
        check({e.tag, ".RegWrite_out"}, 32'(rw_m), 32'(e.rw));
        check({e.tag, ".MemtoReg_out"}, 32'(m2r_m), 32'(e.m2r));
      end
    end
  end

  task automatic nop_inputs();
    branch_target = '0; result = '0; wdata = '0; dst = '0;
    zero = 1'b0; branch = 1'b0; mrd = 1'b0; mwr = 1'b0; rw_in = 1'b0; m2r_in = 1'b0;
  endtask

  task automatic idle(input int k);
    nop_inputs();
    valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  // Drives one instruction at a falling edge, pushes its expectation, and returns at
  // the falling edge after its completion edge.
  task automatic issue(input string tag, input int s, input word_t res, input word_t wd,
                       input logic [4:0] d, input logic rd, input logic wr,
                       input logic rw, input logic m2r, input logic chk,
                       input word_t exp_rd, input int exp_stall);
    exp_t e;
    int   n;
    sel = s;
    branch_target = '0; branch = 1'b0; zero = 1'b0;
    result = res; wdata = wd; dst = d; mrd = rd; mwr = wr; rw_in = rw; m2r_in = m2r;
    valid = 1'b1;
    e.rd = exp_rd; e.alu = res; e.wba = d; e.rw = rw; e.m2r = m2r; e.chk = chk; e.tag = tag;
    exp_q.push_back(e);
    n = 0;
    #1;
    while (stall_m && n < 40) begin
      if (n > 0) check({tag, ".bubble"}, 32'(rw_m), 32'd0);
      n++;
      @(negedge clk);
      #1;
    end
    if (n > 0) check({tag, ".bubble_end"}, 32'(rw_m), 32'd0);
    check({tag, ".stall_cycles"}, 32'(n), 32'(exp_stall));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    nop_inputs();
    repeat (2) @(negedge clk);
    #1;
    check("reset.stall",     32'(stall_m), 32'd0);
    check("reset.ReadData",  rd_m, 32'd0);
    check("reset.ALUResult", alu_m, 32'd0);
    check("reset.WBAddress", 32'(wba_m), 32'd0);
    check("reset.ctrl",      {30'd0, rw_m, m2r_m}, 32'd0);
    @(negedge clk);
    rst = 3'b111;
    idle(1);

    // Latency 0: store then load, write-priority, R-type, alias.
    issue("t1_store", 0, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 0);
    issue("t1_load",  0, 32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 0);
    issue("rw_both",  0, 32'h10, 32'hCAFEF00D, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 0);
    issue("rw_after", 0, 32'h12, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 0);
    issue("t5_rtype", 0, 32'h7, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 0);
    issue("t6_store", 0, 32'h400, 32'h1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 0);
    issue("t6_load0", 0, 32'h000, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1, 0);
    issue("t6_high",  0, 32'hFFFF_F403, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1, 0);
    idle(1);

    // Branch resolution is combinational.
    branch = 1'b1; zero = 1'b1; branch_target = 32'h0040_0040;
    #1;
    check("t3_pcsrc_taken", 32'(pcsrc_m), 32'd1);
    check("t3_pc_branch",   pcb_m, 32'h0040_0040);
    check("t3_no_stall",    32'(stall_m), 32'd0);
    zero = 1'b0;
    #1;
    check("t3_pcsrc_not",   32'(pcsrc_m), 32'd0);
    idle(1);

    // Latency 3: back-to-back store, R-type, load.
    sel = 2;
    idle(1);
    issue("t2_store", 2, 32'h20, 32'h12345678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 3);
    issue("t2_rtype", 2, 32'h55, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 0);
    issue("t2_load",  2, 32'h20, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h12345678, 3);
    idle(1);

    // Latency 2: reset during the second stall cycle drops the store.
    sel = 1;
    idle(1);
    issue("t4_old", 1, 32'h30, 32'h11111111, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 2);
    result = 32'h30; wdata = 32'hA5A5A5A5; mwr = 1'b1; valid = 1'b0;
    @(negedge clk);
    #1;
    check("t4_stalling",     32'(stall_m), 32'd1);
    rst[1] = 1'b0;
    #1;
    check("t4_rst_stall",    32'(stall_m), 32'd0);
    check("t4_rst_alu",      alu_m, 32'd0);
    check("t4_rst_regwrite", 32'(rw_m), 32'd0);
    @(negedge clk);
    nop_inputs();
    rst[1] = 1'b1;
    idle(1);
    issue("t4_load", 1, 32'h30, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11111111, 2);
    idle(3);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
